// File: rtl/instr_stats_unit.sv
// Instruction-mix statistics: eight live event counters fed by the retiring opcode,
// with sticky overflow flags and an atomic snapshot into shadow registers for readout.
module instr_stats_unit #(
  parameter int WIDTH    = 32,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [5:0]       op,
  input  logic             halt,
  input  logic             clr,
  input  logic             snap,
  input  logic [2:0]       rd_sel,
  output logic [WIDTH-1:0] rd_data,
  output logic [7:0]       ovf,
  output logic             snap_done
);

  localparam int NCNT = 8;
  localparam int CYCLES  = 0;
  localparam int RETIRED = 1;
  localparam int CLS_R   = 2;
  localparam int CLS_I   = 3;
  localparam int CLS_J   = 4;
  localparam int CLS_MEM = 5;
  localparam int CLS_BR  = 6;
  localparam int CLS_UNK = 7;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_live   [NCNT];
  logic [WIDTH-1:0] r_shadow [NCNT];
  logic [7:0]       r_ovf;
  logic             r_snapDone;

  logic       w_isR;
  logic       w_isI;
  logic       w_isJ;
  logic       w_isMem;
  logic       w_isBr;
  logic       w_isUnk;
  logic [7:0] w_inc;

  // MEM and BRANCH opcodes are a subset of the I class; exactly one of R/I/J/UNKNOWN fires.
  always_comb begin
    w_isR   = 1'b0;
    w_isI   = 1'b0;
    w_isJ   = 1'b0;
    w_isMem = 1'b0;
    w_isBr  = 1'b0;
    w_isUnk = 1'b0;
    case (op)
      6'b000000: w_isR = 1'b1;
      6'b000010, 6'b000011: w_isJ = 1'b1;
      6'b100011, 6'b101011: begin
        w_isI   = 1'b1;
        w_isMem = 1'b1;
      end
      6'b000100, 6'b000101: begin
        w_isI  = 1'b1;
        w_isBr = 1'b1;
      end
      6'b001000, 6'b001001, 6'b001010, 6'b001011,
      6'b001100, 6'b001101, 6'b001111: w_isI = 1'b1;
      default: w_isUnk = 1'b1;
    endcase
  end

  always_comb begin
    w_inc          = 8'd0;
    w_inc[CYCLES]  = !halt;
    w_inc[RETIRED] = !halt && instr_valid;
    w_inc[CLS_R]   = !halt && instr_valid && w_isR;
    w_inc[CLS_I]   = !halt && instr_valid && w_isI;
    w_inc[CLS_J]   = !halt && instr_valid && w_isJ;
    w_inc[CLS_MEM] = !halt && instr_valid && w_isMem;
    w_inc[CLS_BR]  = !halt && instr_valid && w_isBr;
    w_inc[CLS_UNK] = !halt && instr_valid && w_isUnk;
  end

  // Shadow capture reads the pre-edge live value, so snap+clr is an atomic read-and-clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCNT; i++) begin
        r_live[i]   <= '0;
        r_shadow[i] <= '0;
      end
      r_ovf      <= 8'd0;
      r_snapDone <= 1'b0;
    end else begin
      r_snapDone <= snap;
      for (int i = 0; i < NCNT; i++) begin
        if (snap) begin
          r_shadow[i] <= r_live[i];
        end
        if (clr) begin
          r_live[i] <= '0;
          r_ovf[i]  <= 1'b0;
        end else if (w_inc[i]) begin
          if (r_live[i] == '1) begin
            r_ovf[i]  <= 1'b1;
            r_live[i] <= SATURATE ? r_live[i] : '0;
          end else begin
            r_live[i] <= r_live[i] + ONE;
          end
        end
      end
    end
  end

  assign rd_data   = r_shadow[rd_sel];
  assign ovf       = r_ovf;
  assign snap_done = r_snapDone;

endmodule

// File: doc/instr_stats_unit.md
# instr_stats_unit

Parametrised instruction-mix statistics unit for the MIPS core. It observes the retiring instruction's opcode and keeps eight live event counters: cycles, retired instructions, R/I/J class, memory, branch and unrecognised opcodes. Counters have a configurable width and a wrap or saturate mode, plus sticky overflow flags. An atomic snapshot into shadow registers lets software or the testbench read a coherent set of values while counting continues. It sits beside the datapath, driven by the decoded opcode and a retire strobe from control.

## Interface
- WIDTH, 32: width of every live and shadow counter (2..64).
- SATURATE, 0: 0 = counters wrap to 0 on overflow; 1 = counters hold at all-ones.

- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- instr_valid  in  1  an instruction retires this cycle; gates all class counters and the retired counter.
- op  in  6  opcode of the retiring instruction; don't-care when instr_valid=0.
- halt  in  1  freeze: no counter (including cycles) increments while 1.
- clr  in  1  synchronous clear of live counters and overflow flags.
- snap  in  1  capture live counters into shadow registers.
- rd_sel  in  3  shadow counter index for rd_data.
- rd_data  out  WIDTH  shadow[rd_sel], combinational.
- ovf  out  8  sticky overflow flag per live counter, bit i = counter i.
- snap_done  out  1  one-cycle pulse the cycle after a capture.

## Operation
- Counter index: 0 CYCLES, 1 RETIRED, 2 R, 3 I, 4 J, 5 MEM, 6 BRANCH, 7 UNKNOWN.
- Classification when instr_valid=1:
  - R: op=000000.
  - J: op=000010 (j) or 000011 (jal).
  - I: op in {001000 addi, 001001 addiu, 001010 slti, 001011 sltiu, 001100 andi, 001101 ori, 001111 lui, 100011 lw, 101011 sw, 000100 beq, 000101 bne}.
  - MEM: lw or sw. BRANCH: beq or bne. MEM and BRANCH also count as I.
  - UNKNOWN: any other opcode. Exactly one of R/I/J/UNKNOWN increments per retired instruction.
- Increment enables (halt=0 required for all):
  - CYCLES: every cycle.
  - RETIRED: instr_valid.
  - Class counters: instr_valid and a class match.
- Overflow:
  - The condition is an increment while the counter equals 2^WIDTH-1.
  - WRAP mode: the counter becomes 0 and ovf[i] is set.
  - SATURATE mode: the counter stays at all-ones and ovf[i] is set.
  - ovf bits remain set until clr or rst.
- clr has priority over increment. After a clr edge, all live counters and ovf are 0; an event in the clr cycle is not counted. Shadow registers are unaffected by clr.
- Snapshot: on an edge with snap=1, shadow[i] takes live[i] as it was before that edge's update. snap_done=1 in the following cycle only.
- snap and clr in the same cycle form an atomic read-and-clear: the shadow gets the pre-clear values and the live counters go to 0.
- snap has effect while halt=1; halt only freezes increments.

## Timing
- rst asserted at any time, including mid-snapshot: live, shadow, ovf and snap_done go to 0 immediately and stay there until the first edge after rst deasserts.
- An increment is visible on the live counter one edge after the qualifying cycle. It is visible in rd_data only after a subsequent snap edge.
- rd_data follows rd_sel combinationally, with zero latency.
- Back-to-back snap on consecutive cycles: each edge captures. snap_done stays high for each following cycle.
- ovf[i] rises on the same edge on which the overflowing increment is applied.

## Test plan
- Reset, then 6 valid cycles with op = 000000, 000010, 000011, 001000, 100011, 000100, then snap.
  - Required shadow, read via rd_sel 0..7: CYCLES=6, RETIRED=6, R=1, I=3, J=2, MEM=1, BRANCH=1, UNKNOWN=0.
  - snap_done pulses exactly one cycle.
- instr_valid=0 for 3 cycles with op=000000, then op=111111 valid for 2 cycles, then snap.
  - Required increments: CYCLES +5, RETIRED +2, R +0, UNKNOWN +2.
- halt=1 for 4 cycles with valid lw, then snap → no counter changes, including CYCLES.
- WIDTH=4, SATURATE=0, 17 cycles, then snap → CYCLES=1 and ovf[0]=1.
  - The same sequence with SATURATE=1 → CYCLES=15 and ovf[0]=1.
  - A following clr → ovf=0 and CYCLES=0.
- snap and clr together, with live R=5 and valid addi in that cycle.
  - Required: shadow R=5, live R=0 after the edge, the addi is not counted, snap_done=1 next cycle.
- Assert rst asynchronously mid-cycle with nonzero counters and shadow → rd_data=0 and ovf=0 before the next clock edge.
